core_task_dispatcher: RTL and testbench

- Producer side of the core-availability mask.
- Accepts tasks from the front-end over a valid/ready handshake and picks the next free core round-robin, strictly after the last core granted, wrapping at the top.
- Presents each task to the core array and holds it until that core acknowledges, then marks the core busy.
- Cores release themselves with a done pulse, which frees their mask bit.

---
 rtl/core_task_dispatcher.sv | 143 ++++++++++++++
 tb/tb_core_task_dispatcher.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/core_task_dispatcher.sv
// Round-robin dispatcher: one-cycle accept-to-present latency, holds the task until the target core acks; task_ready low while dispatching or all busy.
// Optional per-core busy watchdog enabled by defining CORE_DISPATCH_TIMEOUT_EN.
module core_task_dispatcher #(
  parameter int NUM_CORES      = 4,
  parameter int ID_W           = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 task_valid,
  input  logic [DATA_W-1:0]    task_data,
  output logic                 task_ready,
  output logic                 disp_valid,
  output logic [ID_W-1:0]      disp_core_id,
  output logic [DATA_W-1:0]    disp_data,
  input  logic [NUM_CORES-1:0] disp_ack,
  input  logic [NUM_CORES-1:0] done,
  output logic [NUM_CORES-1:0] busy_mask,
  output logic                 all_busy,
  output logic [NUM_CORES-1:0] timeout_err
);

  localparam int CW = ID_W + 1;

  typedef enum logic {IDLE, DISPATCH} state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      last_id;
  logic [ID_W-1:0]      sel;
  logic [CW-1:0]        cand;
  logic                 found;
  logic                 accept;
  logic                 ack_hit;
  logic [NUM_CORES-1:0] free;
  logic [NUM_CORES-1:0] expire;
  logic [NUM_CORES-1:0] busy_nxt;

  assign free       = ~busy_mask;
  assign task_ready = (state == IDLE) && (free != '0);
  assign all_busy   = &busy_mask;

  // Scan starts one past the last grant, so last_id is the final candidate.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = {1'b0, last_id} + CW'(k);
      if (cand >= CW'(NUM_CORES)) cand = cand - CW'(NUM_CORES);
      if (!found && free[cand[ID_W-1:0]]) begin
        sel   = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ack_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (task_valid && task_ready) begin
          accept    = 1'b1;
          state_nxt = DISPATCH;
        end
      end
      DISPATCH: begin
        if (disp_ack[disp_core_id]) begin
          ack_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Set after clear: an ack landing with done for the same core leaves it busy.
  always_comb begin
    busy_nxt = busy_mask & ~done & ~expire;
    if (ack_hit) busy_nxt[disp_core_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_valid   <= 1'b0;
      disp_core_id <= '0;
      disp_data    <= '0;
      last_id      <= ID_W'(NUM_CORES - 1);
      busy_mask    <= '0;
    end else begin
      busy_mask <= busy_nxt;
      if (accept) begin
        disp_valid   <= 1'b1;
        disp_core_id <= sel;
        disp_data    <= task_data;
      end
      if (ack_hit) begin
        disp_valid <= 1'b0;
        last_id    <= disp_core_id;
      end
    end
  end

`ifdef CORE_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]     cnt [NUM_CORES];
  logic [NUM_CORES-1:0] timeout_q;

  // A done in the expiry cycle wins and suppresses the error pulse.
  always_comb begin
    expire = '0;
    for (int i = 0; i < NUM_CORES; i++)
      expire[i] = busy_mask[i] && (cnt[i] == CNT_W'(TIMEOUT_CYCLES - 1)) && !done[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) cnt[i] <= '0;
    end else begin
      timeout_q <= expire;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (ack_hit && (disp_core_id == ID_W'(i))) cnt[i] <= '0;
        else if (busy_mask[i])                     cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign expire      = '0;
  assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_core_task_dispatcher.sv
// Directed bench for core_task_dispatcher: vector table for grant order and stalls, plus hand-written reset/overlap sequences.
module tb_core_task_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        task_valid;
  logic [31:0] task_data;
  logic        task_ready;
  logic        disp_valid;
  logic [1:0]  disp_core_id;
  logic [31:0] disp_data;
  logic [3:0]  disp_ack;
  logic [3:0]  done;
  logic [3:0]  busy_mask;
  logic        all_busy;
  logic [3:0]  timeout_err;

  int errors = 0;
  int checks = 0;

  core_task_dispatcher #(
    .NUM_CORES(4), .ID_W(2), .DATA_W(32), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .reset(reset),
    .task_valid(task_valid), .task_data(task_data), .task_ready(task_ready),
    .disp_valid(disp_valid), .disp_core_id(disp_core_id), .disp_data(disp_data),
    .disp_ack(disp_ack), .done(done),
    .busy_mask(busy_mask), .all_busy(all_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tv;
    logic [31:0] td;
    logic [3:0]  ack;
    logic [3:0]  dn;
    logic        ev;
    logic [1:0]  eid;
    logic [31:0] edat;
    logic [3:0]  ebusy;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] A0 = 32'hA0, A1 = 32'hA1, A2 = 32'hA2, A3 = 32'hA3;
  localparam logic [31:0] A4 = 32'hA4, A5 = 32'hA5;
  localparam logic [31:0] B0 = 32'hB0, B1 = 32'hB1, B2 = 32'hB2;
  localparam logic [31:0] C0 = 32'hC0, C1 = 32'hC1, C2 = 32'hC2, C3 = 32'hC3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [1:0] eid,
                            input logic [31:0] edat, input logic [3:0] ebusy, input logic erdy);
    chk({tag, ".disp_valid"},   32'(disp_valid),   32'(ev));
    chk({tag, ".disp_core_id"}, 32'(disp_core_id), 32'(eid));
    chk({tag, ".disp_data"},    disp_data,         edat);
    chk({tag, ".busy_mask"},    32'(busy_mask),    32'(ebusy));
    chk({tag, ".all_busy"},     32'(all_busy),     32'(ebusy == 4'hF));
    chk({tag, ".task_ready"},   32'(task_ready),   32'(erdy));
    chk({tag, ".timeout_err"},  32'(timeout_err),  32'h0);
  endtask

  task automatic drive(input logic tv, input logic [31:0] td, input logic [3:0] ack, input logic [3:0] dn);
    task_valid = tv;
    task_data  = td;
    disp_ack   = ack;
    done       = dn;
  endtask

  initial begin
    // tv, td, ack, done | disp_valid, id, data, busy, ready  (outputs checked before the edge)
    vecs.push_back('{1'b1, A0, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, A1, 4'b0001, 4'b0000, 1'b1, 2'd0, A0,    4'b0000, 1'b0});
    vecs.push_back('{1'b1, A1, 4'b0000, 4'b0000, 1'b0, 2'd0, A0,    4'b0001, 1'b1});
    vecs.push_back('{1'b1, A2, 4'b0010, 4'b0000, 1'b1, 2'd1, A1,    4'b0001, 1'b0});
    vecs.push_back('{1'b1, A2, 4'b0000, 4'b0000, 1'b0, 2'd1, A1,    4'b0011, 1'b1});
    vecs.push_back('{1'b1, A3, 4'b0100, 4'b0000, 1'b1, 2'd2, A2,    4'b0011, 1'b0});
    vecs.push_back('{1'b1, A3, 4'b0000, 4'b0000, 1'b0, 2'd2, A2,    4'b0111, 1'b1});
    vecs.push_back('{1'b1, A4, 4'b1000, 4'b0000, 1'b1, 2'd3, A3,    4'b0111, 1'b0});
    vecs.push_back('{1'b1, A4, 4'b0000, 4'b0000, 1'b0, 2'd3, A3,    4'b1111, 1'b0});
    vecs.push_back('{1'b1, A4, 4'b0000, 4'b0100, 1'b0, 2'd3, A3,    4'b1111, 1'b0});
    vecs.push_back('{1'b1, A4, 4'b0000, 4'b0000, 1'b0, 2'd3, A3,    4'b1011, 1'b1});
    vecs.push_back('{1'b1, A5, 4'b0100, 4'b0000, 1'b1, 2'd2, A4,    4'b1011, 1'b0});
    vecs.push_back('{1'b0, A5, 4'b0000, 4'b0000, 1'b0, 2'd2, A4,    4'b1111, 1'b0});
    vecs.push_back('{1'b0, A5, 4'b0000, 4'b1010, 1'b0, 2'd2, A4,    4'b1111, 1'b0});
    vecs.push_back('{1'b1, B0, 4'b0000, 4'b0000, 1'b0, 2'd2, A4,    4'b0101, 1'b1});
    vecs.push_back('{1'b1, B1, 4'b1000, 4'b0000, 1'b1, 2'd3, B0,    4'b0101, 1'b0});
    vecs.push_back('{1'b1, B1, 4'b0000, 4'b0000, 1'b0, 2'd3, B0,    4'b1101, 1'b1});
    vecs.push_back('{1'b1, B2, 4'b1101, 4'b0000, 1'b1, 2'd1, B1,    4'b1101, 1'b0});
    vecs.push_back('{1'b1, B2, 4'b1101, 4'b0000, 1'b1, 2'd1, B1,    4'b1101, 1'b0});
    vecs.push_back('{1'b1, B2, 4'b1101, 4'b0000, 1'b1, 2'd1, B1,    4'b1101, 1'b0});
    vecs.push_back('{1'b1, B2, 4'b0010, 4'b0000, 1'b1, 2'd1, B1,    4'b1101, 1'b0});
    vecs.push_back('{1'b0, B2, 4'b0000, 4'b1111, 1'b0, 2'd1, B1,    4'b1111, 1'b0});
    vecs.push_back('{1'b0, B2, 4'b0000, 4'b0000, 1'b0, 2'd1, B1,    4'b0000, 1'b1});

    reset = 1'b1;
    drive(1'b0, 32'h0, 4'b0, 4'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eid, vecs[i].edat,
                 vecs[i].ebusy, vecs[i].erdy);
      drive(vecs[i].tv, vecs[i].td, vecs[i].ack, vecs[i].dn);
      @(negedge clk);
    end

    // Foreign ack bits and done on the pending (still free) core are ignored.
    reset = 1'b1;
    drive(1'b0, 32'h0, 4'b0, 4'b0);
    @(negedge clk);
    reset = 1'b0;
    expect_out("rst2", 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1);
    drive(1'b1, C0, 4'b0000, 4'b0000);
    @(negedge clk);
    expect_out("c0_present", 1'b1, 2'd0, C0, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 4'b1110, 4'b0001);
      @(negedge clk);
      expect_out($sformatf("c0_hold%0d", k), 1'b1, 2'd0, C0, 4'b0000, 1'b0);
    end

    // ack and done for the same core: set wins.
    drive(1'b0, 32'h0, 4'b0001, 4'b0001);
    @(negedge clk);
    expect_out("ack_done_same", 1'b0, 2'd0, C0, 4'b0001, 1'b1);

    // ack for core 1 alongside done for core 0: both apply.
    drive(1'b1, C1, 4'b0000, 4'b0000);
    @(negedge clk);
    expect_out("c1_present", 1'b1, 2'd1, C1, 4'b0001, 1'b0);
    drive(1'b0, 32'h0, 4'b0010, 4'b0001);
    @(negedge clk);
    expect_out("ack_done_diff", 1'b0, 2'd1, C1, 4'b0010, 1'b1);

    // Reset while a task is pending drops it and frees everything.
    drive(1'b1, C2, 4'b0000, 4'b0000);
    @(negedge clk);
    expect_out("c2_present", 1'b1, 2'd2, C2, 4'b0010, 1'b0);
    reset = 1'b1;
    drive(1'b0, 32'h0, 4'b0000, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    expect_out("rst_mid", 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1);
    drive(1'b1, C3, 4'b0000, 4'b0000);
    @(negedge clk);
    expect_out("post_rst_grant", 1'b1, 2'd0, C3, 4'b0000, 1'b0);
    drive(1'b0, 32'h0, 4'b0001, 4'b0000);
    @(negedge clk);
    expect_out("post_rst_ack", 1'b0, 2'd0, C3, 4'b0001, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
